// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: takes ops from the E/M register, runs data-cache
// transactions, aligns load data and emits one writeback pulse per accepted instruction.
module mem_stage_lsu #(
  parameter int unsigned WORD_SIZE       = 32,
  parameter int unsigned INSTR_TYPE_SZ   = 3,
  parameter int unsigned ROB_ENTRY_WIDTH = 4,
  parameter int unsigned ITYPE_LOAD      = 1,
  parameter int unsigned ITYPE_STORE     = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       valid,
  input  logic [INSTR_TYPE_SZ-1:0]   instruction_type,
  input  logic [2:0]                 funct3,
  input  logic [WORD_SIZE-1:0]       aluResult,
  input  logic [WORD_SIZE-1:0]       s2,
  input  logic [ROB_ENTRY_WIDTH-1:0] rob_id,
  output logic                       stall,
  output logic                       dc_req_valid,
  input  logic                       dc_req_ready,
  output logic                       dc_req_we,
  output logic [WORD_SIZE-1:0]       dc_req_addr,
  output logic [WORD_SIZE-1:0]       dc_req_wdata,
  output logic [3:0]                 dc_req_be,
  input  logic                       dc_resp_valid,
  input  logic [WORD_SIZE-1:0]       dc_resp_data,
  output logic                       wb_valid,
  output logic [WORD_SIZE-1:0]       wb_data,
  output logic [ROB_ENTRY_WIDTH-1:0] wb_rob_id,
  output logic                       wb_misaligned
);

  localparam logic [2:0] F3B  = 3'b000;
  localparam logic [2:0] F3H  = 3'b001;
  localparam logic [2:0] F3W  = 3'b010;
  localparam logic [2:0] F3BU = 3'b100;
  localparam logic [2:0] F3HU = 3'b101;

  typedef enum logic [1:0] {StIdle, StReq, StWait, StDrain} state_e;

  state_e                     state_q;
  logic [2:0]                 op_funct3_q;
  logic [1:0]                 op_off_q;
  logic [ROB_ENTRY_WIDTH-1:0] op_rob_q;

  logic                 is_load, is_store, is_mem, misaligned;
  logic [3:0]           st_be;
  logic [WORD_SIZE-1:0] st_wdata, ld_data;
  logic [7:0]           ld_byte;
  logic [15:0]          ld_half;

  // Decode of the op currently offered by E/M; unknown size codes take the exception path.
  always_comb begin
    is_load  = (instruction_type == INSTR_TYPE_SZ'(ITYPE_LOAD));
    is_store = (instruction_type == INSTR_TYPE_SZ'(ITYPE_STORE));
    is_mem   = is_load | is_store;
    case (funct3)
      F3B:     misaligned = 1'b0;
      F3H:     misaligned = aluResult[0];
      F3W:     misaligned = |aluResult[1:0];
      F3BU:    misaligned = !is_load;
      F3HU:    misaligned = !is_load | aluResult[0];
      default: misaligned = 1'b1;
    endcase
  end

  always_comb begin
    case (funct3[1:0])
      2'b00: begin
        st_be    = 4'b0001 << aluResult[1:0];
        st_wdata = {4{s2[7:0]}};
      end
      2'b01: begin
        st_be    = 4'b0011 << {aluResult[1], 1'b0};
        st_wdata = {2{s2[15:0]}};
      end
      default: begin
        st_be    = 4'hF;
        st_wdata = s2;
      end
    endcase
  end

  always_comb begin
    ld_byte = dc_resp_data[{op_off_q, 3'b000} +: 8];
    ld_half = op_off_q[1] ? dc_resp_data[31:16] : dc_resp_data[15:0];
    case (op_funct3_q)
      F3B:     ld_data = {{(WORD_SIZE-8){ld_byte[7]}}, ld_byte};
      F3BU:    ld_data = {{(WORD_SIZE-8){1'b0}}, ld_byte};
      F3H:     ld_data = {{(WORD_SIZE-16){ld_half[15]}}, ld_half};
      F3HU:    ld_data = {{(WORD_SIZE-16){1'b0}}, ld_half};
      default: ld_data = dc_resp_data;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= StIdle;
      op_funct3_q   <= '0;
      op_off_q      <= '0;
      op_rob_q      <= '0;
      stall         <= 1'b0;
      dc_req_valid  <= 1'b0;
      dc_req_we     <= 1'b0;
      dc_req_addr   <= '0;
      dc_req_wdata  <= '0;
      dc_req_be     <= '0;
      wb_valid      <= 1'b0;
      wb_data       <= '0;
      wb_rob_id     <= '0;
      wb_misaligned <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      case (state_q)
        StIdle: begin
          // A flush in the accept cycle kills the op, including its single-cycle writeback.
          if (valid && !flush) begin
            if (!is_mem || misaligned) begin
              wb_valid      <= 1'b1;
              wb_data       <= is_mem ? '0 : aluResult;
              wb_rob_id     <= rob_id;
              wb_misaligned <= is_mem;
            end else begin
              state_q      <= StReq;
              stall        <= 1'b1;
              dc_req_valid <= 1'b1;
              dc_req_we    <= is_store;
              dc_req_addr  <= {aluResult[WORD_SIZE-1:2], 2'b00};
              dc_req_wdata <= is_store ? st_wdata : '0;
              dc_req_be    <= is_store ? st_be : 4'h0;
              op_funct3_q  <= funct3;
              op_off_q     <= aluResult[1:0];
              op_rob_q     <= rob_id;
            end
          end
        end
        StReq: begin
          if (flush) begin
            state_q      <= StIdle;
            stall        <= 1'b0;
            dc_req_valid <= 1'b0;
          end else if (dc_req_ready) begin
            dc_req_valid <= 1'b0;
            if (dc_req_we) begin
              state_q       <= StIdle;
              stall         <= 1'b0;
              wb_valid      <= 1'b1;
              wb_data       <= '0;
              wb_rob_id     <= op_rob_q;
              wb_misaligned <= 1'b0;
            end else begin
              state_q <= StWait;
            end
          end
        end
        StWait: begin
          if (dc_resp_valid) begin
            state_q <= StIdle;
            stall   <= 1'b0;
            if (!flush) begin
              wb_valid      <= 1'b1;
              wb_data       <= ld_data;
              wb_rob_id     <= op_rob_q;
              wb_misaligned <= 1'b0;
            end
          end else if (flush) begin
            // The load is already in the cache; its response must still be absorbed.
            state_q <= StDrain;
          end
        end
        StDrain: begin
          if (dc_resp_valid) begin
            state_q <= StIdle;
            stall   <= 1'b0;
          end
        end
        default: begin
          state_q      <= StIdle;
          stall        <= 1'b0;
          dc_req_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
